// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache prefetch and dcache misses; returns are routed by tag owner.
// Grant, mem command, accept and return routing are same-cycle combinational; state updates at posedge.
// No queuing: a rejected request (resp tag 0) must be re-presented. MEM_ARB_ANTI_STARVE_EN adds icache anti-starvation.
package mem_arb_pkg;
    localparam int NUM_MEM_TAGS = 15;
    typedef logic [$clog2(NUM_MEM_TAGS+1)-1:0] MEM_TAG;
    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} MEM_COMMAND;
    typedef struct packed {
        logic valid;
        ADDR  addr;
    } ADDR_PACKET;
endpackage

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT      = 4,
    parameter int MAX_I_OUTSTANDING = NUM_MEM_TAGS - 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  ADDR_PACKET                          i_req,
    output logic                                i_req_accepted,
    output MEM_TAG                              i_req_tag,
    output MEM_BLOCK                            i_return_data,
    output MEM_TAG                              i_return_tag,
    input  logic                                d_req_valid,
    input  MEM_COMMAND                          d_req_cmd,
    input  ADDR                                 d_req_addr,
    input  MEM_BLOCK                            d_req_data,
    output logic                                d_req_accepted,
    output MEM_TAG                              d_req_tag,
    output MEM_BLOCK                            d_return_data,
    output MEM_TAG                              d_return_tag,
    output MEM_COMMAND                          mem_cmd,
    output ADDR                                 mem_addr,
    output MEM_BLOCK                            mem_data,
    input  MEM_TAG                              mem_resp_tag,
    input  MEM_BLOCK                            mem_data_in,
    input  MEM_TAG                              mem_data_tag,
    output logic [$clog2(NUM_MEM_TAGS+1)-1:0]   i_outstanding
);
    localparam int OUT_W = $clog2(NUM_MEM_TAGS + 1);

    // Entry 0 is never written, so tag 0 always reads as "no owner".
    logic [NUM_MEM_TAGS:0] tag_valid;
    logic [NUM_MEM_TAGS:0] tag_owner;

    logic i_elig, grant_i, grant_d, prio_i;
    logic ret_hit, ret_owner, i_ret, load_acc;

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    assign prio_i = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign prio_i = 1'b0;
`endif

    assign i_elig  = i_req.valid && (i_outstanding < OUT_W'(MAX_I_OUTSTANDING));
    assign grant_i = i_elig && (!d_req_valid || prio_i);
    assign grant_d = d_req_valid && !grant_i;

    always_comb begin
        mem_cmd  = MEM_NONE;
        mem_addr = '0;
        mem_data = '0;
        if (grant_d) begin
            mem_cmd  = d_req_cmd;
            mem_addr = d_req_addr;
            mem_data = d_req_data;
        end else if (grant_i) begin
            mem_cmd  = MEM_LOAD;
            mem_addr = i_req.addr;
        end
    end

    assign i_req_accepted = grant_i && (mem_resp_tag != '0);
    assign d_req_accepted = grant_d && (mem_resp_tag != '0);
    assign i_req_tag      = i_req_accepted ? mem_resp_tag : '0;
    assign d_req_tag      = d_req_accepted ? mem_resp_tag : '0;
    assign load_acc       = i_req_accepted || (d_req_accepted && d_req_cmd == MEM_LOAD);

    assign ret_hit   = (mem_data_tag != '0) && tag_valid[mem_data_tag];
    assign ret_owner = tag_owner[mem_data_tag];
    assign i_ret     = ret_hit && !ret_owner;

    assign i_return_tag  = i_ret ? mem_data_tag : '0;
    assign i_return_data = i_ret ? mem_data_in : '0;
    assign d_return_tag  = (ret_hit && ret_owner) ? mem_data_tag : '0;
    assign d_return_data = (ret_hit && ret_owner) ? mem_data_in : '0;

    // Clear precedes set so a tag recycled in its own return cycle keeps the new owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid     <= '0;
            tag_owner     <= '0;
            i_outstanding <= '0;
        end else begin
            if (ret_hit)
                tag_valid[mem_data_tag] <= 1'b0;
            if (load_acc) begin
                tag_valid[mem_resp_tag] <= 1'b1;
                tag_owner[mem_resp_tag] <= grant_d;
            end
            case ({i_req_accepted, i_ret})
                2'b10:   i_outstanding <= i_outstanding + OUT_W'(1);
                2'b01:   i_outstanding <= i_outstanding - OUT_W'(1);
                default: i_outstanding <= i_outstanding;
            endcase
        end
    end

`ifdef MEM_ARB_ANTI_STARVE_EN
    always_ff @(posedge clock) begin
        if (reset || !i_req.valid || i_req_accepted)
            starve_cnt <= '0;
        else if (i_elig && !prio_i)
            starve_cnt <= starve_cnt + SW'(1);
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle table plus starvation, tag-limit and reset sequences.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_ANTI_STARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       i_vld;
        ADDR        i_addr;
        logic       d_vld;
        MEM_COMMAND d_cmd;
        ADDR        d_addr;
        MEM_BLOCK   d_data;
        MEM_TAG     resp;
        MEM_TAG     dtag;
        MEM_BLOCK   din;
        MEM_COMMAND e_cmd;
        ADDR        e_addr;
        MEM_BLOCK   e_mdat;
        logic       e_i_acc;
        MEM_TAG     e_i_tag;
        logic       e_d_acc;
        MEM_TAG     e_d_tag;
        MEM_TAG     e_i_rtag;
        MEM_BLOCK   e_i_rdat;
        MEM_TAG     e_d_rtag;
        MEM_BLOCK   e_d_rdat;
        logic [3:0] e_iout;
    } vec_t;

    logic       clock, reset;
    ADDR_PACKET i_req;
    logic       i_req_accepted, d_req_accepted, d_req_valid;
    MEM_TAG     i_req_tag, i_return_tag, d_req_tag, d_return_tag, mem_resp_tag, mem_data_tag;
    MEM_BLOCK   i_return_data, d_return_data, d_req_data, mem_data, mem_data_in;
    MEM_COMMAND d_req_cmd, mem_cmd;
    ADDR        d_req_addr, mem_addr;
    logic [3:0] i_outstanding;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t exp_q[$];
    vec_t tbl[11];

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_req_accepted(i_req_accepted), .i_req_tag(i_req_tag),
        .i_return_data(i_return_data), .i_return_tag(i_return_tag),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_req_accepted(d_req_accepted), .d_req_tag(d_req_tag),
        .d_return_data(d_return_data), .d_return_tag(d_return_tag),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_resp_tag(mem_resp_tag), .mem_data_in(mem_data_in), .mem_data_tag(mem_data_tag),
        .i_outstanding(i_outstanding)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t idle();
        vec_t v;
        v.rst = 0; v.i_vld = 0; v.i_addr = '0; v.d_vld = 0; v.d_cmd = MEM_NONE;
        v.d_addr = '0; v.d_data = '0; v.resp = '0; v.dtag = '0; v.din = '0;
        v.e_cmd = MEM_NONE; v.e_addr = '0; v.e_mdat = '0; v.e_i_acc = 0; v.e_i_tag = '0;
        v.e_d_acc = 0; v.e_d_tag = '0; v.e_i_rtag = '0; v.e_i_rdat = '0;
        v.e_d_rtag = '0; v.e_d_rdat = '0; v.e_iout = '0;
        return v;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act !== expv)
            $display("FAIL %s step %0d: got %0h expected %0h", name, cyc, act, expv);
        else
            pass_cnt++;
    endtask

    // Drive one cycle of stimulus, queue its expectation, and score it at the falling edge.
    task automatic step(input vec_t v, input int cyc);
        vec_t e;
        @(posedge clock); #1;
        reset        = v.rst;
        i_req        = '{valid: v.i_vld, addr: v.i_addr};
        d_req_valid  = v.d_vld;
        d_req_cmd    = v.d_cmd;
        d_req_addr   = v.d_addr;
        d_req_data   = v.d_data;
        mem_resp_tag = v.resp;
        mem_data_tag = v.dtag;
        mem_data_in  = v.din;
        exp_q.push_back(v);
        @(negedge clock);
        e = exp_q.pop_front();
        chk("mem_cmd",        cyc, 64'(mem_cmd),        64'(e.e_cmd));
        chk("mem_addr",       cyc, 64'(mem_addr),       64'(e.e_addr));
        chk("mem_data",       cyc, mem_data,            e.e_mdat);
        chk("i_req_accepted", cyc, 64'(i_req_accepted), 64'(e.e_i_acc));
        chk("i_req_tag",      cyc, 64'(i_req_tag),      64'(e.e_i_tag));
        chk("d_req_accepted", cyc, 64'(d_req_accepted), 64'(e.e_d_acc));
        chk("d_req_tag",      cyc, 64'(d_req_tag),      64'(e.e_d_tag));
        chk("i_return_tag",   cyc, 64'(i_return_tag),   64'(e.e_i_rtag));
        chk("i_return_data",  cyc, i_return_data,       e.e_i_rdat);
        chk("d_return_tag",   cyc, 64'(d_return_tag),   64'(e.e_d_rtag));
        chk("d_return_data",  cyc, d_return_data,       e.e_d_rdat);
        chk("i_outstanding",  cyc, 64'(i_outstanding),  64'(e.e_iout));
    endtask

    initial begin
        vec_t v;
        logic gi;
        reset = 1'b1;
        i_req = '0; d_req_valid = 0; d_req_cmd = MEM_NONE; d_req_addr = '0; d_req_data = '0;
        mem_resp_tag = '0; mem_data_tag = '0; mem_data_in = '0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 11; i++) tbl[i] = idle();
        tbl[1].i_vld = 1; tbl[1].i_addr = 32'h100; tbl[1].resp = 3;
        tbl[1].e_cmd = MEM_LOAD; tbl[1].e_addr = 32'h100; tbl[1].e_i_acc = 1; tbl[1].e_i_tag = 3;
        tbl[2].dtag = 3; tbl[2].din = 64'hDEAD;
        tbl[2].e_i_rtag = 3; tbl[2].e_i_rdat = 64'hDEAD; tbl[2].e_iout = 1;
        tbl[3].d_vld = 1; tbl[3].d_cmd = MEM_STORE; tbl[3].d_addr = 32'h200; tbl[3].d_data = 64'h55; tbl[3].resp = 2;
        tbl[3].e_cmd = MEM_STORE; tbl[3].e_addr = 32'h200; tbl[3].e_mdat = 64'h55; tbl[3].e_d_acc = 1; tbl[3].e_d_tag = 2;
        tbl[4].dtag = 2; tbl[4].din = 64'h77;
        tbl[5].i_vld = 1; tbl[5].i_addr = 32'h140; tbl[5].resp = 5;
        tbl[5].e_cmd = MEM_LOAD; tbl[5].e_addr = 32'h140; tbl[5].e_i_acc = 1; tbl[5].e_i_tag = 5;
        tbl[6].d_vld = 1; tbl[6].d_cmd = MEM_LOAD; tbl[6].d_addr = 32'h300; tbl[6].resp = 5;
        tbl[6].dtag = 5; tbl[6].din = 64'hBEEF;
        tbl[6].e_cmd = MEM_LOAD; tbl[6].e_addr = 32'h300; tbl[6].e_d_acc = 1; tbl[6].e_d_tag = 5;
        tbl[6].e_i_rtag = 5; tbl[6].e_i_rdat = 64'hBEEF; tbl[6].e_iout = 1;
        tbl[7].dtag = 5; tbl[7].din = 64'hCAFE; tbl[7].e_d_rtag = 5; tbl[7].e_d_rdat = 64'hCAFE;
        tbl[8].dtag = 5; tbl[8].din = 64'hF00;
        tbl[9].i_vld = 1; tbl[9].i_addr = 32'h180; tbl[9].d_vld = 1; tbl[9].d_cmd = MEM_LOAD; tbl[9].d_addr = 32'h340;
        tbl[9].e_cmd = MEM_LOAD; tbl[9].e_addr = 32'h340;

        for (int i = 0; i < 11; i++) step(tbl[i], i);

        // Both sides request every cycle; icache wins once every STARVE_LIMIT+1 cycles only with anti-starvation.
        v = idle(); v.rst = 1; step(v, 100);
        for (int k = 0; k < 10; k++) begin
            v = idle();
            v.i_vld = 1; v.i_addr = 32'h1000 + 32'(k * 64);
            v.d_vld = 1; v.d_cmd = MEM_STORE; v.d_addr = 32'h2000; v.d_data = 64'(k + 1);
            v.resp = 4'(k + 1);
            gi = ANTI && (k % 5 == 4);
            if (gi) begin
                v.e_cmd = MEM_LOAD; v.e_addr = v.i_addr; v.e_i_acc = 1; v.e_i_tag = 4'(k + 1);
            end else begin
                v.e_cmd = MEM_STORE; v.e_addr = 32'h2000; v.e_mdat = 64'(k + 1);
                v.e_d_acc = 1; v.e_d_tag = 4'(k + 1);
            end
            v.e_iout = (ANTI && k >= 5) ? 4'd1 : 4'd0;
            step(v, 110 + k);
        end

        // Fill the icache in-flight limit, confirm the port goes idle, then free one tag.
        v = idle(); v.rst = 1; v.e_iout = ANTI ? 4'd2 : 4'd0; step(v, 200);
        for (int k = 0; k < 14; k++) begin
            v = idle();
            v.i_vld = 1; v.i_addr = 32'h3000 + 32'(k * 64); v.resp = 4'(k + 1);
            v.e_cmd = MEM_LOAD; v.e_addr = v.i_addr; v.e_i_acc = 1; v.e_i_tag = 4'(k + 1); v.e_iout = 4'(k);
            step(v, 210 + k);
        end
        v = idle(); v.i_vld = 1; v.i_addr = 32'h4000; v.resp = 15; v.e_iout = 14; step(v, 230);
        v.dtag = 1; v.din = 64'h11; v.e_i_rtag = 1; v.e_i_rdat = 64'h11; step(v, 231);
        v = idle(); v.i_vld = 1; v.i_addr = 32'h4000; v.resp = 1;
        v.e_cmd = MEM_LOAD; v.e_addr = 32'h4000; v.e_i_acc = 1; v.e_i_tag = 1; v.e_iout = 13;
        step(v, 232);

        // Reset with three loads in flight drops their ownership.
        v = idle(); v.rst = 1; v.e_iout = 14; step(v, 300);
        for (int k = 0; k < 3; k++) begin
            v = idle();
            v.i_vld = 1; v.i_addr = 32'h5000 + 32'(k * 64); v.resp = 4'(k + 1);
            v.e_cmd = MEM_LOAD; v.e_addr = v.i_addr; v.e_i_acc = 1; v.e_i_tag = 4'(k + 1); v.e_iout = 4'(k);
            step(v, 310 + k);
        end
        v = idle(); v.e_iout = 3; step(v, 320);
        v = idle(); v.rst = 1; v.e_iout = 3; step(v, 321);
        v = idle(); step(v, 322);
        for (int k = 0; k < 3; k++) begin
            v = idle(); v.dtag = 4'(k + 1); v.din = 64'hAB00 + 64'(k);
            step(v, 330 + k);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
